serial_link_arbiter: RTL and testbench
======================================

// Module: serial_link_arbiter
// PURPOSE
//  Shares one registered serial output line among N_REQ parallel-word requesters.
//  Grants one requester at a time using round-robin arbitration.
//  Captures the granted word and shifts it out MSB-first, one bit per clk.
//  Marks the first bit of each frame with frame_sync.
//  Sits in front of the single-bit serial register stage; owns its sequencing.
// PARAMETERS
//  N_REQ       4  number of requesters (>=2)
//  WIDTH       8  bits per frame payload (>=2)
//  GAP_CYCLES  1  idle cycles inserted after each frame (0 allowed)
// PORTS
//  clk          in   1              clock, all logic posedge
//  rst          in   1              reset, synchronous, active-high
//  req_valid    in   N_REQ          requester i has a word pending
//  req_data     in   N_REQ*WIDTH    word i at [i*WIDTH +: WIDTH]
//  req_ready    out  N_REQ          one-hot accept pulse; word i consumed when valid&ready
//  serial_out   out  1              registered serial bit, MSB first
//  frame_sync   out  1              high with the first payload bit only
//  active_id    out  $clog2(N_REQ)  requester currently being shifted
//  busy         out  1              high from accept until the frame's GAP ends
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer=0 (req 0 highest priority); shreg, counters 0.
//  Reset mid-frame aborts it immediately; the partial word is dropped and not retried.
//  FSM: IDLE -> SHIFT -> [PAR] -> [GAP] -> IDLE.
//  IDLE:
//   - If any req_valid, grant first valid index at or after ptr (wrapping).
//   - req_ready[g]=1 for exactly this cycle (combinational from state+valid).
//   - Capture req_data[g] into shreg; active_id<=g; ptr<=g+1 mod N_REQ; busy<=1; -> SHIFT.
//   - If no req_valid, stay; serial_out=0, frame_sync=0.
//  SHIFT: WIDTH cycles.
//   - serial_out<=shreg[WIDTH-1]; shift left.
//   - frame_sync<=1 only on the first shift cycle.
//   - Bit k appears at serial_out k+1 cycles after the accept edge.
//  PAR (macro only): one cycle; serial_out<=parity bit.
//  GAP: GAP_CYCLES cycles; serial_out<=0. GAP_CYCLES==0 skips GAP (SHIFT/PAR -> IDLE).
//  busy falls when the FSM re-enters IDLE. Min frame period = WIDTH+P+GAP_CYCLES+1 clk (P=1 with parity).
//  req_ready is never asserted outside IDLE. A requester may drop valid before grant (no penalty).
//  req_data of non-granted requesters is ignored; granted data is sampled only on the accept edge.
//  Single valid requester repeatedly: granted every period regardless of ptr.
//  Counters sized $clog2(WIDTH+1) and $clog2(GAP_CYCLES+1) (min 1 bit); no wrap beyond terminal count.
// CONFIGURATION
//  SERIAL_ARB_PARITY_EN defined:
//   - adds PAR state after SHIFT; bit = ^word (even parity over the WIDTH payload bits).
//   - frame_sync unchanged.
//  Undefined: no PAR state, P=0, frames are payload-only.
// STRUCTURE
//  Package serial_arb_pkg:
//   - state enum {IDLE, SHIFT, PAR, GAP}
//   - localparam function for id width: max(1, $clog2(n)).
//  Sub-module rr_arbiter (N_REQ, req vector, ptr -> one-hot grant + index), purely combinational.
//  Top holds FSM, shreg, bit/gap counters, ptr, output registers.
// TESTING
//  1. Reset: rst=1 two cycles -> all outputs 0, busy=0, no req_ready while rst high.
//  2. req_valid=0001, data0=8'hB3 -> req_ready=0001 one cycle, then serial_out 1,0,1,1,0,0,1,1; frame_sync only on the first.
//  3. req_valid=1111 held, data i = i+1 -> grant order 0,1,2,3,0; ready one-hot, one per period of 10 clk (GAP=1).
//  4. Parity build, data0=8'h07 -> bit 9 = 1. data0=8'h03 -> bit 9 = 0. Period 11 clk.
//  5. rst asserted at 4th bit of a frame -> next cycle serial_out=0, busy=0; then req2 only valid -> req 2 granted.
//  6. GAP_CYCLES=0, req1 held -> back-to-back frames; frame_sync every WIDTH+1 clk; serial_out=0 for exactly the IDLE cycle.

Source files
------------

// File: rtl/serial_link_arbiter_pkg.sv
// Shared definitions for the serial link arbiter: FSM state codes and the
// helper that sizes requester index fields.
package serial_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t PAR   = 2'd2;
  localparam state_t GAP   = 2'd3;

  // Requester index width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_link_arbiter_rr_arbiter.sv
// Round-robin grant picker: first asserted request at or after ptr,
// wrapping around. Purely combinational.
module rr_arbiter
  import serial_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]           req,
  input  logic [id_width(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]           grant,
  output logic [id_width(N_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IW = id_width(N_REQ);

  logic [IW-1:0] cand;

  // Scan requesters starting at ptr and take the first one found.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_link_arbiter.sv
// Serial link arbiter: round-robin shares one registered serial line among
// N_REQ word requesters, shifting each granted word out MSB-first with a
// frame_sync marker on the first bit and GAP_CYCLES idle cycles after it.
// Optional feature: define SERIAL_ARB_PARITY_EN to append an even-parity bit
// after each payload.
module serial_link_arbiter
  import serial_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       serial_out,
  output logic                       frame_sync,
  output logic [id_width(N_REQ)-1:0] active_id,
  output logic                       busy
);

  localparam int IW = id_width(N_REQ);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Where the FSM goes once the payload (and parity, if built) is out.
  localparam state_t AFTER_PAYLOAD = (GAP_CYCLES > 0) ? GAP : IDLE;
`ifdef SERIAL_ARB_PARITY_EN
  localparam state_t AFTER_SHIFT = PAR;
`else
  localparam state_t AFTER_SHIFT = AFTER_PAYLOAD;
`endif

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] words [N_REQ];
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_any;
`ifdef SERIAL_ARB_PARITY_EN
  logic             par_bit;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Unpack the flat data bus so the granted word can be picked by index.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      words[k] = req_data[k*WIDTH +: WIDTH];
    end
  end

  // Accept pulse is only offered while idle and out of reset.
  assign req_ready = (!rst && state == IDLE) ? grant : '0;

  // Frame sequencer: grant/capture, shift payload, optional parity, gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      active_id  <= '0;
      busy       <= 1'b0;
      serial_out <= 1'b0;
      frame_sync <= 1'b0;
`ifdef SERIAL_ARB_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      serial_out <= 1'b0;
      frame_sync <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            shreg     <= words[grant_idx];
            active_id <= grant_idx;
            ptr       <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            state     <= SHIFT;
`ifdef SERIAL_ARB_PARITY_EN
            par_bit   <= ^words[grant_idx];
`endif
          end
        end
        SHIFT: begin
          serial_out <= shreg[WIDTH-1];
          shreg      <= {shreg[WIDTH-2:0], 1'b0};
          frame_sync <= (bit_cnt == '0);
          if (bit_cnt == LAST_BIT) begin
            gap_cnt <= '0;
            state   <= AFTER_SHIFT;
            busy    <= (AFTER_SHIFT != IDLE);
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef SERIAL_ARB_PARITY_EN
        PAR: begin
          serial_out <= par_bit;
          gap_cnt    <= '0;
          state      <= AFTER_PAYLOAD;
          busy       <= (AFTER_PAYLOAD != IDLE);
        end
`endif
        GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Self-checking bench for serial_link_arbiter. Two instances: one with a
// one-cycle gap, one with no gap. A frame-level model predicts every output
// each cycle; directed tests pin specific waveforms with literal values.
module tb_serial_link_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int FAR = 1000;
`ifdef SERIAL_ARB_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]   req_valid [2];
  logic [N*W-1:0] req_data  [2];
  logic [N-1:0]   req_ready [2];
  logic           serial_out[2];
  logic           frame_sync[2];
  logic [IW-1:0]  active_id [2];
  logic           busy      [2];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  logic model_on = 1'b0;

  int         m_ptr [2];
  int         m_edge[2];
  logic [W-1:0] m_word[2];
  int         m_id  [2];

  int order[5] = '{0, 1, 2, 3, 0};

  serial_link_arbiter #(.N_REQ(N), .WIDTH(W), .GAP_CYCLES(1)) dut_gap1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_data(req_data[0]), .req_ready(req_ready[0]),
    .serial_out(serial_out[0]), .frame_sync(frame_sync[0]),
    .active_id(active_id[0]), .busy(busy[0])
  );

  serial_link_arbiter #(.N_REQ(N), .WIDTH(W), .GAP_CYCLES(0)) dut_gap0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_data(req_data[1]), .req_ready(req_ready[1]),
    .serial_out(serial_out[1]), .frame_sync(frame_sync[1]),
    .active_id(active_id[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame length in clock edges after the accept edge until idle again.
  function automatic int flen(input int i);
    return W + P + ((i == 0) ? 1 : 0);
  endfunction

  // Round-robin rule: first valid index at or after p, wrapping; -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[IW'((p + k) % N)]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Serial bit expected m_edge edges after the accept edge.
  function automatic logic expSerial(input int i);
    int e;
    e = m_edge[i];
    if (e >= 1 && e <= W) return m_word[i][W-e];
    if (P == 1 && e == W + 1) return ^m_word[i];
    return 1'b0;
  endfunction

  function automatic logic [N-1:0] expReady(input int i);
    int g;
    if (rst || m_edge[i] < flen(i)) return '0;
    g = pick(req_valid[i], m_ptr[i]);
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input int inst, input logic [N-1:0] v, input logic [N*W-1:0] d);
    req_valid[inst] = v;
    req_data[inst]  = d;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(0, '0, '0);
    applyStimulus(1, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic waitReady(input int inst, input int maxc, input string tag, output int idx);
    idx = -1;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (req_ready[inst] != '0) begin
        for (int b = 0; b < N; b++) if (req_ready[inst][b]) idx = b;
        return;
      end
    end
    checks++;
    fails++;
    $display("[TB] FAIL %s_timeout: got no req_ready within %0d cycles, required one", tag, maxc);
  endtask

  task automatic waitSync(input int inst, input int maxc, output int waited);
    waited = 0;
    for (int n = 1; n <= maxc; n++) begin
      @(negedge clk);
      if (frame_sync[inst]) begin
        waited = n;
        return;
      end
    end
    checks++;
    fails++;
    $display("[TB] FAIL sync_timeout: got no frame_sync within %0d cycles, required one", maxc);
  endtask

  // Send one word from requester 0 of the gap-1 instance and record the
  // payload bits plus the bit that follows them.
  task automatic captureFrame(input logic [W-1:0] word, output logic [W:0] bits,
                              output logic [W-1:0] syncs);
    int idx;
    applyStimulus(0, 4'b0001, {24'hA5C3_3C, word});
    waitReady(0, 30, "cap", idx);
    checkOutput("cap_grant", idx, 0);
    @(posedge clk);
    #1 applyStimulus(0, '0, '0);
    @(negedge clk);
    for (int b = W; b >= 0; b--) begin
      @(negedge clk);
      bits[b] = serial_out[0];
      if (b > 0) syncs[b-1] = frame_sync[0];
    end
  endtask

  // Frame-level reference model, advanced once per clock edge.
  always @(posedge clk) begin
    if (rst) begin
      model_on <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_ptr[i]  <= 0;
        m_edge[i] <= FAR;
        m_word[i] <= '0;
        m_id[i]   <= 0;
      end
    end else if (model_on) begin
      for (int i = 0; i < 2; i++) begin
        if (m_edge[i] < flen(i)) begin
          m_edge[i] <= m_edge[i] + 1;
        end else if (pick(req_valid[i], m_ptr[i]) >= 0) begin
          m_word[i] <= req_data[i][pick(req_valid[i], m_ptr[i]) * W +: W];
          m_id[i]   <= pick(req_valid[i], m_ptr[i]);
          m_ptr[i]  <= (pick(req_valid[i], m_ptr[i]) + 1) % N;
          m_edge[i] <= 0;
        end else begin
          m_edge[i] <= FAR;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("serial_out%0d", i), 32'(serial_out[i]), 32'(expSerial(i)));
        checkOutput($sformatf("frame_sync%0d", i), 32'(frame_sync[i]), 32'(m_edge[i] == 1));
        checkOutput($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_edge[i] < flen(i)));
        checkOutput($sformatf("active_id%0d", i), 32'(active_id[i]), 32'(m_id[i]));
        checkOutput($sformatf("req_ready%0d", i), 32'(req_ready[i]), 32'(expReady(i)));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W:0]   bits;
    logic [W-1:0] syncs;
    int idx;
    int stamp[5];
    int waited;
    int zeros;
    int n;

    // Reset with every requester asking: nothing may be accepted.
    rst = 1'b1;
    applyStimulus(0, 4'b1111, 32'h1234_5678);
    applyStimulus(1, 4'b1111, 32'h1234_5678);
    @(negedge clk);
    checkOutput("rst_ready_pre", 32'(req_ready[0]), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready[0]), 0);
    checkOutput("rst_serial", 32'(serial_out[0]), 0);
    checkOutput("rst_sync", 32'(frame_sync[0]), 0);
    checkOutput("rst_busy", 32'(busy[0]), 0);
    checkOutput("rst_id", 32'(active_id[0]), 0);
    applyStimulus(0, '0, '0);
    applyStimulus(1, '0, '0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single frame of 8'hB3: bits 1,0,1,1,0,0,1,1, sync only on the first.
    captureFrame(8'hB3, bits, syncs);
    checkOutput("b3_payload", 32'(bits[W:1]), 32'hB3);
    checkOutput("b3_sync", 32'(syncs), 32'h80);
    checkOutput("b3_after", 32'(bits[0]), (P == 1) ? 32'(^8'hB3) : 0);
    repeat (4) @(posedge clk);

    // All four requesting: order 0,1,2,3,0, one accept per frame period.
    resetDut();
    applyStimulus(0, 4'b1111, {8'd4, 8'd3, 8'd2, 8'd1});
    for (int g = 0; g < 5; g++) begin
      waitReady(0, 20, "rr", idx);
      stamp[g] = cyc;
      checkOutput($sformatf("rr_order%0d", g), idx, order[g]);
      if (g > 0) checkOutput($sformatf("rr_period%0d", g), stamp[g] - stamp[g-1], 10 + P);
    end
    @(posedge clk);
    #1 applyStimulus(0, '0, '0);
    repeat (14) @(posedge clk);

    // Bit after the payload: parity when built in, otherwise a gap zero.
    resetDut();
    captureFrame(8'h07, bits, syncs);
    checkOutput("p07_bit9", 32'(bits[0]), (P == 1) ? 1 : 0);
    repeat (4) @(posedge clk);
    captureFrame(8'h03, bits, syncs);
    checkOutput("p03_bit9", 32'(bits[0]), 0);
    repeat (4) @(posedge clk);

    // Reset while the fourth bit is on the line aborts the frame.
    resetDut();
    applyStimulus(0, 4'b0001, 32'h0000_00FF);
    waitReady(0, 10, "abort", idx);
    @(posedge clk);
    #1 applyStimulus(0, '0, '0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_bit4", 32'(serial_out[0]), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(0, 4'b0100, 32'h00A5_0000);
    @(negedge clk);
    checkOutput("abort_serial", 32'(serial_out[0]), 0);
    checkOutput("abort_busy", 32'(busy[0]), 0);
    checkOutput("abort_ready", 32'(req_ready[0]), 32'b0100);
    @(posedge clk);
    #1 applyStimulus(0, '0, '0);
    @(negedge clk);
    checkOutput("abort_id", 32'(active_id[0]), 2);
    repeat (12) @(posedge clk);

    // No gap, requester 1 held: back-to-back frames with one zero slot each
    // (plus the parity bit, which is 0 for 8'hFF, when parity is built).
    resetDut();
    applyStimulus(1, 4'b0010, 32'h0000_FF00);
    waitSync(1, 20, waited);
    for (int f = 0; f < 3; f++) begin
      zeros = 0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!serial_out[1]) zeros++;
      end while (!frame_sync[1] && n < 30);
      checkOutput($sformatf("g0_period%0d", f), n, 9 + P);
      checkOutput($sformatf("g0_zeros%0d", f), zeros, 1 + P);
    end
    @(posedge clk);
    #1 applyStimulus(1, '0, '0);
    repeat (12) @(posedge clk);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
